bitbang_serializer: RTL and testbench

//   Parametrised serial bit-banger. Accepts a WIDTH-bit word over a valid/ready handshake.

---
 rtl/bitbang_pkg.sv | 16 +
 rtl/bitbang_tick.sv | 32 +++
 rtl/bitbang_serializer.sv | 141 ++++++++++++++
 tb/tb_bitbang_serializer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bitbang_pkg.sv
// rtl/bitbang_pkg.sv - shared types, constants and helpers for the bit-bang serializer
package bitbang_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   localparam logic IDLE_LEVEL_DEFAULT = 1'b1;

   // Number of bits on the wire per word, including start/stop when framed.
   function automatic int unsigned frame_len(input int unsigned width, input bit framed);
      return width + (framed ? 32'd2 : 32'd0);
   endfunction

endpackage

// File: rtl/bitbang_tick.sv
// rtl/bitbang_tick.sv - DIV-cycle bit strobe, restartable so each frame starts phase-aligned
module bitbang_tick #(
   parameter int unsigned DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == CW'(DIV - 1));

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clr || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/bitbang_serializer.sv
// rtl/bitbang_serializer.sv - valid/ready word in, registered single-pin serial frame out
module bitbang_serializer
   import bitbang_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned DIV        = 2,
   parameter bit          MSB_FIRST  = 1'b0,
   parameter bit          FRAMED     = 1'b0,
   parameter logic        IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             abort,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   localparam int unsigned N  = frame_len(WIDTH, FRAMED);
   localparam int unsigned BW = $clog2(N + 1);

   state_e          state_q, state_d;
   logic [N-1:0]    shreg_q, shreg_d;
   logic [N-1:0]    frame_w, shifted_w;
   logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
   logic            sout_q, sout_d;
   logic            done_q, done_d;
   logic            accept_w, tick_w, last_w, clr_w, first_w, next_w;

   // Start/stop are packed around the data so one shift path serves both modes.
   if (FRAMED) begin : g_framed
      if (MSB_FIRST) begin : g_msb
         assign frame_w = {~IDLE_LEVEL, in_data, IDLE_LEVEL};
      end else begin : g_lsb
         assign frame_w = {IDLE_LEVEL, in_data, ~IDLE_LEVEL};
      end
   end else begin : g_plain
      assign frame_w = in_data;
   end

   if (MSB_FIRST) begin : g_shl
      assign shifted_w = shreg_q << 1;
      assign first_w   = frame_w[N-1];
      assign next_w    = shifted_w[N-1];
   end else begin : g_shr
      assign shifted_w = shreg_q >> 1;
      assign first_w   = frame_w[0];
      assign next_w    = shifted_w[0];
   end

   assign accept_w = in_valid & in_ready;
   assign last_w   = (bit_cnt_q == BW'(N - 1));
   assign clr_w    = accept_w | (abort & busy);

   bitbang_tick #(
      .DIV (DIV)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_w),
      .tick  (tick_w)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept_w) state_d = SEND;
         SEND: if (abort || (tick_w && last_w)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state_q == IDLE);
      busy     = (state_q == SEND);
   end

   always_comb begin
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      sout_d    = sout_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept_w) begin
               shreg_d   = frame_w;
               bit_cnt_d = '0;
               sout_d    = first_w;
            end
         end
         SEND: begin
            if (abort) begin
               bit_cnt_d = '0;
               sout_d    = IDLE_LEVEL;
            end else if (tick_w) begin
               if (last_w) begin
                  bit_cnt_d = '0;
                  sout_d    = IDLE_LEVEL;
                  done_d    = 1'b1;
               end else begin
                  shreg_d   = shifted_w;
                  bit_cnt_d = bit_cnt_q + BW'(1);
                  sout_d    = next_w;
               end
            end
         end
         default: begin
            sout_d = IDLE_LEVEL;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         sout_q    <= IDLE_LEVEL;
         done_q    <= 1'b0;
      end else begin
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         sout_q    <= sout_d;
         done_q    <= done_d;
      end
   end

   assign sout = sout_q;
   assign done = done_q;

endmodule

// File: tb/tb_bitbang_serializer.sv
// tb/tb_bitbang_serializer.sv - randomized self-checking bench over three serializer configurations
module tb_bitbang_serializer;

   localparam int W_C   [3] = '{8, 8, 4};
   localparam int DIV_C [3] = '{2, 3, 1};
   localparam int MSB_C [3] = '{0, 1, 0};
   localparam int FR_C  [3] = '{0, 1, 0};

   logic       clk;
   logic       rst_n;
   logic [7:0] in_data  [3];
   logic       in_valid [3];
   logic       abort    [3];
   logic       in_ready [3];
   logic       sout     [3];
   logic       busy     [3];
   logic       done     [3];

   int n_cmp = 0;
   int n_err = 0;

   bitbang_serializer #(.WIDTH(8), .DIV(2), .MSB_FIRST(1'b0), .FRAMED(1'b0), .IDLE_LEVEL(1'b1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .abort(abort[0]), .sout(sout[0]), .busy(busy[0]), .done(done[0]));

   bitbang_serializer #(.WIDTH(8), .DIV(3), .MSB_FIRST(1'b1), .FRAMED(1'b1), .IDLE_LEVEL(1'b1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .abort(abort[1]), .sout(sout[1]), .busy(busy[1]), .done(done[1]));

   bitbang_serializer #(.WIDTH(4), .DIV(1), .MSB_FIRST(1'b0), .FRAMED(1'b0), .IDLE_LEVEL(1'b1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data[2][3:0]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .abort(abort[2]), .sout(sout[2]), .busy(busy[2]), .done(done[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got=timeout exp=finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Bit j of the wire frame for configuration d, straight from the framing rules.
   function automatic logic exp_bit(input int d, input logic [7:0] w, input int j);
      int n, di;
      n = W_C[d] + (FR_C[d] != 0 ? 2 : 0);
      if (FR_C[d] != 0) begin
         if (j == 0)     return 1'b0;
         if (j == n - 1) return 1'b1;
         di = j - 1;
      end else begin
         di = j;
      end
      return (MSB_C[d] != 0) ? w[W_C[d] - 1 - di] : w[di];
   endfunction

   task automatic start_word(input int d, input logic [7:0] w);
      @(negedge clk);
      in_data[d]  = w;
      in_valid[d] = 1'b1;
   endtask

   // Entered at the negedge just before the accepting edge.
   task automatic run_frame(input int d, input logic [7:0] w, input bit keep,
                            input logic [7:0] nxt, input bit poke);
      int t;
      t = (W_C[d] + (FR_C[d] != 0 ? 2 : 0)) * DIV_C[d];
      check("ready_before_accept", in_ready[d], 1);
      for (int c = 0; c < t; c++) begin
         @(negedge clk);
         if (c == 0) begin
            abort[d] = 1'b0;
            if (keep) begin
               in_data[d] = nxt;
            end else begin
               in_valid[d] = 1'b0;
               in_data[d]  = 8'($urandom);
            end
         end
         if (poke && c == 1) in_valid[d] = 1'b1;
         if (poke && c == 2) in_valid[d] = 1'b0;
         check("sout_bit", sout[d], exp_bit(d, w, c / DIV_C[d]));
         check("busy_in_frame", busy[d], 1);
         check("ready_in_frame", in_ready[d], 0);
         check("done_in_frame", done[d], 0);
      end
      @(negedge clk);
      check("sout_after_frame", sout[d], 1);
      check("busy_after_frame", busy[d], 0);
      check("done_pulse", done[d], 1);
      check("ready_after_frame", in_ready[d], 1);
      if (!keep) begin
         @(negedge clk);
         check("done_one_cycle", done[d], 0);
         check("busy_stays_idle", busy[d], 0);
      end
   endtask

   task automatic run_abort(input int d, input logic [7:0] w, input int at);
      start_word(d, w);
      for (int c = 0; c <= at; c++) begin
         @(negedge clk);
         if (c == 0) in_valid[d] = 1'b0;
         check("sout_before_abort", sout[d], exp_bit(d, w, c / DIV_C[d]));
         if (c == at) abort[d] = 1'b1;
      end
      @(negedge clk);
      abort[d] = 1'b0;
      check("abort_sout", sout[d], 1);
      check("abort_busy", busy[d], 0);
      check("abort_ready", in_ready[d], 1);
      check("abort_done", done[d], 0);
      repeat (2) begin
         @(negedge clk);
         check("abort_no_done", done[d], 0);
      end
   endtask

   initial begin
      logic [7:0] w;
      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         in_data[d]  = 8'h00;
         in_valid[d] = 1'b0;
         abort[d]    = 1'b0;
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         check("reset_sout", sout[d], 1);
         check("reset_busy", busy[d], 0);
         check("reset_done", done[d], 0);
         check("reset_ready", in_ready[d], 1);
      end
      rst_n = 1'b1;

      start_word(0, 8'hD2);
      run_frame(0, 8'hD2, 1'b0, 8'h00, 1'b0);
      start_word(1, 8'hA5);
      run_frame(1, 8'hA5, 1'b0, 8'h00, 1'b0);

      start_word(0, 8'h01);
      run_frame(0, 8'h01, 1'b1, 8'hFF, 1'b0);
      run_frame(0, 8'hFF, 1'b0, 8'h00, 1'b0);

      run_abort(0, 8'h5A, 5);
      run_abort(1, 8'h0F, 7);

      @(negedge clk);
      abort[0] = 1'b1;
      @(negedge clk);
      check("idle_abort_busy", busy[0], 0);
      check("idle_abort_sout", sout[0], 1);
      in_data[0]  = 8'h96;
      in_valid[0] = 1'b1;
      run_frame(0, 8'h96, 1'b0, 8'h00, 1'b0);

      start_word(0, 8'h00);
      @(negedge clk);
      in_valid[0] = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_sout", sout[0], 1);
      check("async_reset_busy", busy[0], 0);
      check("async_reset_ready", in_ready[0], 1);
      check("async_reset_done", done[0], 0);
      @(negedge clk);
      rst_n = 1'b1;
      start_word(0, 8'h3C);
      run_frame(0, 8'h3C, 1'b0, 8'h00, 1'b0);

      start_word(2, 8'h09);
      run_frame(2, 8'h09, 1'b0, 8'h00, 1'b1);

      for (int d = 0; d < 3; d++) begin
         for (int i = 0; i < 6; i++) begin
            w = 8'($urandom);
            repeat ($urandom_range(0, 3)) begin
               @(negedge clk);
               check("gap_busy", busy[d], 0);
            end
            start_word(d, w);
            if ($urandom_range(0, 3) == 0) abort[d] = 1'b1;
            run_frame(d, w, 1'b0, 8'h00, $urandom_range(0, 1) == 1);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
